// File: rtl/avm_pio_master_pkg.sv
// Shared definitions for the Avalon-MM PIO master.
//   state_e       : transaction FSM states (IDLE, BUS_WR, BUS_RD, RD_LAT, RESP)
//   OP_READ/WRITE : encoding of cmd_write
//   RL_MIN/RL_MAX : legal range of the fixed slave read latency
//   LAT_CNT_W     : width of the read-latency counter, sized for RL_MAX
package avm_pio_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUS_WR = 3'd1,
        ST_BUS_RD = 3'd2,
        ST_RD_LAT = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int RL_MIN    = 0;
    localparam int RL_MAX    = 3;
    localparam int LAT_CNT_W = $clog2(RL_MAX + 1);

endpackage

// File: rtl/avm_pio_master_stall_timer.sv
// Stall/timeout and read-latency counters for the Avalon-MM PIO master.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   stall_clr_i       : clear the stall counter (new command accepted)
//   stall_en_i        : this bus cycle is stalled by waitrequest
//   stall_expired_o   : this stalled cycle is the TIMEOUT-th consecutive one
//   lat_load_i        : slave accepted the read; restart latency count
//   lat_en_i          : a latency-wait cycle is in progress
//   lat_done_o        : current latency-wait cycle is the one carrying readdata
module avm_stall_timer
    import avm_pio_master_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_clr_i,
    input  logic stall_en_i,
    output logic stall_expired_o,
    input  logic lat_load_i,
    input  logic lat_en_i,
    output logic lat_done_o
);

    localparam int STALL_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_LAST = (READ_LATENCY > 0) ? int'(READ_LATENCY) - 1 : 0;

    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q,   lat_cnt_d;

    // Expiry is flagged during the stalled cycle itself so that the strobes
    // are held for exactly TIMEOUT stalled cycles before dropping.
    assign stall_expired_o = stall_en_i && (stall_cnt_q == STALL_W'(TIMEOUT - 1));
    assign lat_done_o      = lat_en_i && (lat_cnt_q == LAT_CNT_W'(LAT_LAST));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_en_i && !stall_expired_o) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (lat_load_i) begin
            lat_cnt_d = '0;
        end else if (lat_en_i && !lat_done_o) begin
            lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            lat_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

endmodule

// File: rtl/avm_pio_master.sv
// Avalon-MM single-transaction initiator for PIO-style slaves.
// One command in -> one bus transaction -> one response out; no pipelining.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/ready/write/address/wdata : command stream in
//   rsp_valid/ready/rdata/error         : response stream out
//   avm_*                      : Avalon-MM initiator port (registered outputs)
//   dbg_state_o                : current FSM state for observation
module avm_pio_master
    import avm_pio_master_pkg::*;
#(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output state_e            dbg_state_o
);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
    logic                read_n_q, read_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                error_q, error_d;

    logic stall_clr, stall_en, stall_expired;
    logic lat_load, lat_en, lat_done;

    assign stall_en = ((state_q == ST_BUS_WR) || (state_q == ST_BUS_RD)) && avm_waitrequest;
    assign lat_en   = (state_q == ST_RD_LAT);

    avm_stall_timer #(
        .TIMEOUT      (TIMEOUT),
        .READ_LATENCY (READ_LATENCY)
    ) u_timer (
        .clk             (clk),
        .reset           (reset),
        .stall_clr_i     (stall_clr),
        .stall_en_i      (stall_en),
        .stall_expired_o (stall_expired),
        .lat_load_i      (lat_load),
        .lat_en_i        (lat_en),
        .lat_done_o      (lat_done)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        stall_clr = 1'b0;
        lat_load  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    stall_clr = 1'b1;
                    addr_d    = cmd_address;
                    wdata_d   = cmd_wdata;
                    state_d   = (cmd_write == OP_WRITE) ? ST_BUS_WR : ST_BUS_RD;
                end
            end
            ST_BUS_WR: begin
                if (!avm_waitrequest) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    error_d = 1'b0;
                end else if (stall_expired) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    error_d = 1'b1;
                end
            end
            ST_BUS_RD: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        // Zero-latency slave: data is on the bus in the accept cycle.
                        state_d = ST_RESP;
                        rdata_d = avm_readdata;
                        error_d = 1'b0;
                    end else begin
                        lat_load = 1'b1;
                        state_d  = ST_RD_LAT;
                    end
                end else if (stall_expired) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    error_d = 1'b1;
                end
            end
            ST_RD_LAT: begin
                if (lat_done) begin
                    state_d = ST_RESP;
                    rdata_d = avm_readdata;
                    error_d = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // All status outputs are registered and derived from the next state,
        // so chipselect and its strobe always switch on the same edge.
        cmd_ready_d = (state_d == ST_IDLE);
        cs_d        = (state_d == ST_BUS_WR) || (state_d == ST_BUS_RD);
        write_n_d   = (state_d != ST_BUS_WR);
        read_n_d    = (state_d != ST_BUS_RD);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            read_n_q    <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            read_n_q    <= read_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_read_n     = read_n_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_error      = error_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_avm_pio_master.sv
module tb_avm_pio_master;
    import avm_pio_master_pkg::*;

    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_address = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic        avm_read_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'hDEAD_BEEF;
    logic        avm_waitrequest;
    state_e      dbg_state;

    avm_pio_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .dbg_state_o(dbg_state)
    );

    // ---------------- PIO slave model (1-cycle read latency) ----------------
    logic [31:0] out_port   = '0;
    int          stall_cfg  = 0;
    int          strobe_age = 0;
    logic        force_wait = 1'b0;
    int          wr_low_cnt = 0;
    int          wr_acc_cnt = 0;
    int          pairing_err = 0;

    assign avm_waitrequest = force_wait || (avm_chipselect && (strobe_age < stall_cfg));

    always @(posedge clk) begin
        strobe_age <= avm_chipselect ? strobe_age + 1 : 0;
        if (avm_chipselect && !avm_write_n) begin
            wr_low_cnt <= wr_low_cnt + 1;
            if (!avm_waitrequest) begin
                wr_acc_cnt <= wr_acc_cnt + 1;
                if (avm_address == 2'd0) out_port <= avm_writedata;
            end
        end
        // Read data is valid only in the single cycle after acceptance.
        if (avm_chipselect && !avm_read_n && !avm_waitrequest)
            avm_readdata <= (avm_address == 2'd0) ? out_port : 32'h0;
        else
            avm_readdata <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if ((avm_chipselect != (!avm_write_n || !avm_read_n)) || (!avm_write_n && !avm_read_n))
            pairing_err <= pairing_err + 1;
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] model_out = '0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one command, checked against the model ----------------
    task automatic run_txn(input logic wr, input logic [1:0] a, input logic [31:0] d,
                           input int stalls, input int hold);
        int          n;
        int          strobes;
        logic        exp_er;
        int          exp_str;
        logic [31:0] exp_rd;
        // reference: success if the slave stops stalling before TIMEOUT stalled cycles
        exp_er  = (stalls >= TO);
        exp_str = exp_er ? TO : stalls + 1;
        exp_q.push_back((wr || exp_er) ? 32'h0 : ((a == 2'd0) ? model_out : 32'h0));
        if (wr && !exp_er && a == 2'd0) model_out = d;

        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", 32'(n < 20), 32'd1);
        stall_cfg   = stalls;
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = a;
        cmd_wdata   = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        strobes = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            if (avm_chipselect) strobes++;
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", 32'(n < 100), 32'd1);
        exp_rd = exp_q.pop_front();
        chk("strobe_cycles", 32'(strobes), 32'(exp_str));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_error", 32'(rsp_error), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_error", 32'(rsp_error), 32'(exp_er));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_released", 32'(rsp_valid), 32'd0);
        chk("out_port", out_port, model_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int wl0, wa0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_read_n", 32'(avm_read_n), 32'd1);
        chk("rst_address", 32'(avm_address), 32'd0);
        chk("rst_writedata", avm_writedata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // best-case write 0xA5 to address 0
        wl0 = wr_low_cnt;
        rsp_ready   = 1'b1;
        stall_cfg   = 0;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_address = 2'd0;
        cmd_wdata   = 32'hA5;
        @(negedge clk);                  // cycle 1
        cmd_valid = 1'b0;
        chk("bc_c1_cs", 32'(avm_chipselect), 32'd1);
        chk("bc_c1_write_n", 32'(avm_write_n), 32'd0);
        chk("bc_c1_read_n", 32'(avm_read_n), 32'd1);
        chk("bc_c1_writedata", avm_writedata, 32'hA5);
        chk("bc_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bc_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);                  // cycle 2
        chk("bc_c2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bc_c2_rsp_error", 32'(rsp_error), 32'd0);
        chk("bc_c2_rsp_rdata", rsp_rdata, 32'd0);
        chk("bc_c2_cs", 32'(avm_chipselect), 32'd0);
        @(negedge clk);                  // cycle 3
        rsp_ready = 1'b0;
        model_out = 32'hA5;
        chk("bc_c3_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bc_c3_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bc_out_port", out_port, 32'hA5);
        chk("bc_write_low_cycles", 32'(wr_low_cnt - wl0), 32'd1);

        // reads after the write
        run_txn(1'b0, 2'd0, 32'h0, 0, 0);
        run_txn(1'b0, 2'd1, 32'h0, 0, 0);

        // write 0x3C with 3 stall cycles
        wl0 = wr_low_cnt;
        wa0 = wr_acc_cnt;
        run_txn(1'b1, 2'd0, 32'h3C, 3, 0);
        chk("stall_wr_low_cycles", 32'(wr_low_cnt - wl0), 32'd4);
        chk("stall_wr_accepted", 32'(wr_acc_cnt - wa0), 32'd1);

        // read that times out, then a normal read
        run_txn(1'b0, 2'd0, 32'h0, 50, 0);
        run_txn(1'b0, 2'd0, 32'h0, 0, 0);

        // response back-pressure
        run_txn(1'b0, 2'd0, 32'h0, 1, 5);

        // reset during a stalled read
        force_wait  = 1'b1;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_cs", 32'(avm_chipselect), 32'd1);
        chk("mid_read_n", 32'(avm_read_n), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        chk("mid_rst_read_n", 32'(avm_read_n), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        reset      = 1'b0;
        force_wait = 1'b0;
        @(negedge clk);
        chk("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                    int'($urandom_range(0, 11)), int'($urandom_range(0, 3)));
        end

        chk("strobe_pairing", 32'(pairing_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
